// File: rtl/lsu_pkg.sv
// Shared encodings for the SRAM load/store path: funct3 size codes,
// controller states and the external SRAM data width.
package lsu_pkg;

    localparam int unsigned SRAM_DW = 16;

    localparam logic [2:0] NB_B  = 3'b000;
    localparam logic [2:0] NB_H  = 3'b001;
    localparam logic [2:0] NB_W  = 3'b010;
    localparam logic [2:0] NB_BU = 3'b100;
    localparam logic [2:0] NB_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH0,
        ST_PH1,
        ST_DONE
    } lsu_state_t;

    function automatic logic is_byte(input logic [2:0] nb);
        return (nb == NB_B) || (nb == NB_BU);
    endfunction

    // Unknown size codes are treated as misaligned so they never reach the SRAM.
    function automatic logic is_misaligned(input logic [2:0] nb, input logic [1:0] a);
        case (nb)
            NB_B, NB_BU: return 1'b0;
            NB_H, NB_HU: return a[0];
            NB_W:        return a != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sram_lsu_ctrl_if.sv
// Core-side request bus and SRAM pin bundle of the load/store controller.
interface sram_lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 18
);
    import lsu_pkg::*;

    logic                 i_req;
    logic                 i_wren;
    logic [ADDR_W:0]      i_addr;
    logic [2:0]           i_num_byte;
    logic [31:0]          i_st_data;
    logic [31:0]          o_ld_data;
    logic                 o_stall;
    logic                 o_misalign;
    logic [ADDR_W-1:0]    o_sram_addr;
    logic [SRAM_DW-1:0]   i_sram_dq;
    logic [SRAM_DW-1:0]   o_sram_dq;
    logic                 o_sram_dq_oe;
    logic                 o_sram_ce_n;
    logic                 o_sram_we_n;
    logic                 o_sram_oe_n;
    logic                 o_sram_lb_n;
    logic                 o_sram_ub_n;

    modport master (
        output i_req, i_wren, i_addr, i_num_byte, i_st_data, i_sram_dq,
        input  o_ld_data, o_stall, o_misalign, o_sram_addr, o_sram_dq, o_sram_dq_oe,
               o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
    );

    modport slave (
        input  i_req, i_wren, i_addr, i_num_byte, i_st_data, i_sram_dq,
        output o_ld_data, o_stall, o_misalign, o_sram_addr, o_sram_dq, o_sram_dq_oe,
               o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n
    );

endinterface

// File: rtl/ld_extend.sv
// Load data alignment: byte lane select plus sign/zero extension to 32 bits.
module ld_extend
    import lsu_pkg::*;
(
    input  logic [2:0]         num_byte,
    input  logic               lane,
    input  logic [SRAM_DW-1:0] lo,
    input  logic [SRAM_DW-1:0] hi,
    output logic [31:0]        data
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = lane ? lo[15:8] : lo[7:0];
        data     = '0;
        case (num_byte)
            NB_B:    data = {{24{byte_sel[7]}}, byte_sel};
            NB_BU:   data = {24'h0, byte_sel};
            NB_H:    data = {{16{lo[15]}}, lo};
            NB_HU:   data = {16'h0, lo};
            NB_W:    data = {hi, lo};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/sram_lsu_ctrl.sv
// Multi-cycle load/store controller: splits a 32-bit core access into one or
// two 16-bit asynchronous SRAM phases with programmable wait states.
module sram_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned DW       = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    sram_lsu_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);

    lsu_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                wren_q;
    logic                lane_q;
    logic [2:0]          nb_q;
    logic [DW-1:0]       st_q;
    logic [SRAM_DW-1:0]  lo_q;
    logic [SRAM_DW-1:0]  hi_q;
    logic [SRAM_DW-1:0]  sram_dq;
    logic                dq_oe, ce_n, we_n, oe_n, lb_n, ub_n;
    logic                misaligned;

    assign misaligned = is_misaligned(bus.i_num_byte, bus.i_addr[1:0]);

    assign bus.o_stall      = bus.i_req & (state != ST_DONE);
    assign bus.o_misalign   = bus.i_req & (state == ST_IDLE) & misaligned & ~i_reset;
    assign bus.o_sram_addr  = addr_q;
    assign bus.o_sram_dq    = sram_dq;
    assign bus.o_sram_dq_oe = dq_oe;
    assign bus.o_sram_ce_n  = ce_n;
    assign bus.o_sram_we_n  = we_n;
    assign bus.o_sram_oe_n  = oe_n;
    assign bus.o_sram_lb_n  = lb_n;
    assign bus.o_sram_ub_n  = ub_n;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            lane_q  <= 1'b0;
            nb_q    <= '0;
            st_q    <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            sram_dq <= '0;
            dq_oe   <= 1'b0;
            ce_n    <= 1'b1;
            we_n    <= 1'b1;
            oe_n    <= 1'b1;
            lb_n    <= 1'b1;
            ub_n    <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        nb_q   <= bus.i_num_byte;
                        lane_q <= bus.i_addr[0];
                        wren_q <= bus.i_wren;
                        st_q   <= bus.i_st_data;
                        // Clearing here makes a misaligned request read back as zero.
                        lo_q   <= '0;
                        hi_q   <= '0;
                        if (misaligned) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_PH0;
                            cnt     <= CNT_W'(WAIT_CYC);
                            addr_q  <= bus.i_addr[ADDR_W:1];
                            ce_n    <= 1'b0;
                            oe_n    <= bus.i_wren;
                            we_n    <= ~bus.i_wren;
                            dq_oe   <= bus.i_wren;
                            if (is_byte(bus.i_num_byte)) begin
                                sram_dq <= {2{bus.i_st_data[7:0]}};
                                lb_n    <= bus.i_addr[0];
                                ub_n    <= ~bus.i_addr[0];
                            end else begin
                                sram_dq <= bus.i_st_data[SRAM_DW-1:0];
                                lb_n    <= 1'b0;
                                ub_n    <= 1'b0;
                            end
                        end
                    end
                end
                ST_PH0: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!wren_q) lo_q <= bus.i_sram_dq;
                        if (nb_q == NB_W) begin
                            state   <= ST_PH1;
                            cnt     <= CNT_W'(WAIT_CYC);
                            addr_q  <= addr_q + 1'b1;
                            sram_dq <= st_q[DW-1:SRAM_DW];
                        end else begin
                            state <= ST_DONE;
                            ce_n  <= 1'b1;
                            we_n  <= 1'b1;
                            oe_n  <= 1'b1;
                            lb_n  <= 1'b1;
                            ub_n  <= 1'b1;
                            dq_oe <= 1'b0;
                        end
                    end
                end
                ST_PH1: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!wren_q) hi_q <= bus.i_sram_dq;
                        state <= ST_DONE;
                        ce_n  <= 1'b1;
                        we_n  <= 1'b1;
                        oe_n  <= 1'b1;
                        lb_n  <= 1'b1;
                        ub_n  <= 1'b1;
                        dq_oe <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ld_extend u_ld_extend (
        .num_byte (nb_q),
        .lane     (lane_q),
        .lo       (lo_q),
        .hi       (hi_q),
        .data     (bus.o_ld_data)
    );

endmodule

// File: doc/sram_lsu_ctrl.md
Name: sram_lsu_ctrl

Overview:
- Multi-cycle load/store controller between the core's LSU data path and the board's external 16-bit asynchronous SRAM.
- Splits one 32-bit core request (byte, half or word; signed or unsigned) into one or two SRAM half-word accesses.
- Each access is stretched over programmable wait states.
- Holds the PC (via o_stall) until the access completes, so single-cycle and later cores can use slow external memory.

Parameters:
- ADDR_W, 18, SRAM half-word address width.
- WAIT_CYC, 1, extra cycles each SRAM access phase is held (≥0).
- DW, 32, core data width (fixed at 32; word = two 16-bit phases).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous active-high reset
- i_req  in  1  core requests an SRAM-region access; held stable while o_stall=1
- i_wren  in  1  1=store, 0=load
- i_addr  in  ADDR_W+1  byte address (bit0 = byte lane)
- i_num_byte  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- i_st_data  in  32  store data
- o_ld_data  out  32  aligned, extended load data; valid in DONE
- o_stall  out  1  core holds PC/regfile write while 1 (en_pc = ~o_stall)
- o_misalign  out  1  one-cycle pulse on misaligned request
- o_sram_addr  out  ADDR_W  half-word address
- i_sram_dq  in  16  SRAM read data
- o_sram_dq  out  16  SRAM write data
- o_sram_dq_oe  out  1  drive enable for top-level tristate
- o_sram_ce_n, o_sram_we_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async, any state): state IDLE; all SRAM strobes 1; dq_oe 0; sram_addr 0; o_ld_data 0; o_misalign 0; wait counter 0.
- States: IDLE, PH0, PH1, DONE.
- o_stall = i_req & (state != DONE), combinational. No request → never stalls.
- IDLE, i_req=1:
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0; or num_byte ∉ {000,001,010,100,101}): go to DONE with o_misalign=1 that cycle, no SRAM strobes, ld_data 0.
  - Otherwise: go to PH0, load counter=WAIT_CYC, register the half-word address i_addr[ADDR_W:1].
- PH0 / PH1, each lasting WAIT_CYC+1 cycles:
  - ce_n=0.
  - Load: oe_n=0.
  - Store: we_n=0, dq_oe=1, o_sram_dq = low half (PH0) or high half (PH1) of store data.
  - Byte access: byte replicated on both lanes; lb_n=~(addr[0]==0), ub_n=~(addr[0]==1).
  - Half/word access: lb_n=ub_n=0.
  - On counter==0: loads capture i_sram_dq into the low (PH0) or high (PH1) half-register.
  - Word: PH0 → PH1 with address+1. Byte/half: PH0 → DONE.
- DONE, one cycle:
  - Strobes released to 1 (this is also the write-recovery cycle); o_stall=0; o_ld_data valid.
  - Next state IDLE unconditionally (back-to-back requests restart from IDLE).
- Load extension:
  - LB/LBU: select lane by addr[0], sign/zero extend.
  - LH/LHU: sign/zero extend.
  - LW: {hi,lo}.
- Latency, request seen at cycle 0, W=WAIT_CYC:
  - Byte/half: stall cycles 0..W+1, DONE at cycle W+2.
  - Word: DONE at cycle 2W+3.
  - Misaligned: DONE at cycle 1.
- Address wrap: PH1 address = PH0 + 1 modulo 2^ADDR_W.
- i_req dropping mid-access (protocol violation): the current access still completes to DONE; o_stall follows i_req.
- Reset mid-access: immediate abort; SRAM strobes high asynchronously.

Decomposition:
- Package lsu_pkg:
  - num_byte encodings: NB_B, NB_H, NB_W, NB_BU, NB_HU.
  - State enum type.
  - SRAM half-word width constant.
- Optional sub-module ld_extend (combinational lane select and sign/zero extension). It is reusable by the on-chip LSU.

Test Plan:
- LW at addr 0x0008, WAIT_CYC=1, SRAM hw[4]=0xBEEF, hw[5]=0xDEAD:
  - o_stall high cycles 0–4, sram_addr 4 then 5.
  - Cycle 5: o_ld_data=0xDEADBEEF, stall 0.
- LB at addr 0x0003 with hw[1]=0x80AA:
  - ub_n=0, lb_n=1; o_ld_data=0xFFFFFF80 at cycle 3.
  - Same access as LBU → 0x00000080.
- SW 0x12345678 at addr 0x0010:
  - we_n low in PH0 with dq=0x5678 @ addr 8, then PH1 with dq=0x1234 @ addr 9.
  - Strobes high in DONE.
  - Readback LW returns 0x12345678.
- LH at addr 0x0001:
  - o_misalign pulse at cycle 0, no ce_n activity, ld_data 0, stall released at cycle 1.
- Assert i_reset in PH1 of a word store:
  - Same cycle: we_n, ce_n high, dq_oe 0, state IDLE.
  - After reset release, a new LW completes with nominal latency.
- WAIT_CYC=0 and WAIT_CYC=3 builds:
  - Word DONE at cycles 3 and 9 respectively.
  - Back-to-back LW, SW each show one DONE cycle with stall 0 between.
